// File: rtl/dimmer_core.sv
// LED dimmer: debounced-by-edge up/down buttons set a 16-level brightness step,
// which drives either a common PWM on all ten LEDs or a bar-graph display.
module dimmer_core (
  input  logic        clock_50,
  input  logic        clr_n,
  input  logic        up_n,
  input  logic        down_n,
  input  logic        test,
  input  logic        mode,
  output logic [9:0]  leds,
  output logic [3:0]  stepcounter,
  output logic [17:0] cyclecounter
);

  localparam int unsigned CC_W     = 18;
  localparam int unsigned STEP_W   = 4;
  localparam int unsigned LED_N    = 10;
  localparam int unsigned STEP_MAX = 15;
  localparam int unsigned TEST_MAX = 15;

  // [0],[1] synchronise, [2] holds the previous synchronised sample for edge detection
  logic [2:0] up_sync;
  logic [2:0] dn_sync;
  // Counts edges since reset release so reset-preset flop values never look like a fall
  logic [1:0] settle;

  logic              up_press_c;
  logic              dn_press_c;
  logic [CC_W-1:0]   cc_next_c;
  logic [STEP_W-1:0] pwm_level_c;
  logic              pwm_c;
  logic [LED_N-1:0]  bar_c;

  always_ff @(posedge clock_50 or posedge clr_n) begin
    if (clr_n) begin
      up_sync <= '1;
      dn_sync <= '1;
      settle  <= '0;
    end else begin
      up_sync <= {up_sync[1:0], up_n};
      dn_sync <= {dn_sync[1:0], down_n};
      if (settle != 2'd3) begin
        settle <= 2'(settle + 2'd1);
      end
    end
  end

  always_comb begin
    up_press_c = (settle == 2'd3) && up_sync[2] && !up_sync[1];
    dn_press_c = (settle == 2'd3) && dn_sync[2] && !dn_sync[1];
  end

  always_ff @(posedge clock_50 or posedge clr_n) begin
    if (clr_n) begin
      stepcounter <= '0;
    end else if (up_press_c && !dn_press_c) begin
      if (stepcounter != STEP_W'(STEP_MAX)) begin
        stepcounter <= STEP_W'(stepcounter + STEP_W'(1));
      end
    end else if (dn_press_c && !up_press_c) begin
      if (stepcounter != '0) begin
        stepcounter <= STEP_W'(stepcounter - STEP_W'(1));
      end
    end
  end

  // Short period wraps at 15; a larger value left over from the long period clears at once
  always_comb begin
    cc_next_c = CC_W'(cyclecounter + CC_W'(1));
    if (test && (cyclecounter >= CC_W'(TEST_MAX))) begin
      cc_next_c = '0;
    end
  end

  always_ff @(posedge clock_50 or posedge clr_n) begin
    if (clr_n) begin
      cyclecounter <= '0;
    end else begin
      cyclecounter <= cc_next_c;
    end
  end

  always_comb begin
    pwm_level_c = test ? cyclecounter[3:0] : cyclecounter[CC_W-1:CC_W-STEP_W];
    pwm_c       = (pwm_level_c < stepcounter);
    if (stepcounter >= STEP_W'(LED_N)) begin
      bar_c = '1;
    end else begin
      bar_c = LED_N'((LED_N'(1) << stepcounter) - LED_N'(1));
    end
  end

  always_ff @(posedge clock_50 or posedge clr_n) begin
    if (clr_n) begin
      leds <= '0;
    end else begin
      leds <= mode ? bar_c : {LED_N{pwm_c}};
    end
  end

endmodule

// File: tb/tb_dimmer_core.sv
// Randomised + directed bench for dimmer_core; a per-edge reference model feeds
// expected outputs to a scoreboard checked by an independent monitor.
module tb_dimmer_core;

  logic        clock_50 = 1'b0;
  logic        clr_n    = 1'b1;
  logic        up_n     = 1'b1;
  logic        down_n   = 1'b1;
  logic        test     = 1'b1;
  logic        mode     = 1'b0;
  logic [9:0]  leds;
  logic [3:0]  stepcounter;
  logic [17:0] cyclecounter;

  int total = 0;
  int bad   = 0;

  dimmer_core dut (
    .clock_50     (clock_50),
    .clr_n        (clr_n),
    .up_n         (up_n),
    .down_n       (down_n),
    .test         (test),
    .mode         (mode),
    .leds         (leds),
    .stepcounter  (stepcounter),
    .cyclecounter (cyclecounter)
  );

  always #5 clock_50 = ~clock_50;

  // Reference model state
  int m_step = 0;
  int m_cc   = 0;
  int k      = 0;
  bit su[$];
  bit sd[$];
  int q_leds[$];
  int q_step[$];
  int q_cc[$];

  function automatic int bar_of(input int step);
    int n;
    int v;
    n = (step < 10) ? step : 10;
    v = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < n) v = v + (1 << i);
    end
    return v;
  endfunction

  // A press takes effect on the edge two after the first sample of 0, provided the
  // preceding sample (taken after reset release) was 1.
  always @(posedge clock_50) begin
    int  lvl;
    int  nleds;
    bit  up_p;
    bit  dn_p;
    if (clr_n) begin
      m_step = 0;
      m_cc   = 0;
      k      = 0;
      su.delete();
      sd.delete();
      nleds  = 0;
    end else begin
      lvl   = test ? (m_cc % 16) : (m_cc / 16384);
      nleds = mode ? bar_of(m_step) : ((lvl < m_step) ? 10'h3FF : 0);
      k++;
      su.push_back(up_n);
      sd.push_back(down_n);
      if (su.size() > 4) void'(su.pop_front());
      if (sd.size() > 4) void'(sd.pop_front());
      up_p = (k >= 4) && su[0] && !su[1];
      dn_p = (k >= 4) && sd[0] && !sd[1];
      if (up_p && !dn_p && m_step < 15) m_step++;
      else if (dn_p && !up_p && m_step > 0) m_step--;
      if (test) m_cc = (m_cc >= 15) ? 0 : m_cc + 1;
      else m_cc = (m_cc + 1) % 262144;
    end
    q_leds.push_back(nleds);
    q_step.push_back(m_step);
    q_cc.push_back(m_cc);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard monitor, sampling away from the active edge
  always @(negedge clock_50) begin
    int el;
    int es;
    int ec;
    if (q_cc.size() > 0) begin
      el = q_leds.pop_front();
      es = q_step.pop_front();
      ec = q_cc.pop_front();
      chk("leds", int'(leds), el);
      chk("stepcounter", int'(stepcounter), es);
      chk("cyclecounter", int'(cyclecounter), ec);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock_50);
  endtask

  task automatic press(input bit u, input bit d, input int hold);
    @(negedge clock_50);
    if (u) up_n = 1'b0;
    if (d) down_n = 1'b0;
    cyc(hold);
    up_n   = 1'b1;
    down_n = 1'b1;
    cyc(3);
  endtask

  task automatic do_reset(input int n);
    @(negedge clock_50);
    #2 clr_n = 1'b1;
    #1;
    chk("async_rst_leds", int'(leds), 0);
    chk("async_rst_step", int'(stepcounter), 0);
    chk("async_rst_cc", int'(cyclecounter), 0);
    cyc(n);
    clr_n = 1'b0;
  endtask

  initial begin
    int r;
    cyc(3);
    clr_n = 1'b0;
    cyc(20);

    // single step with PWM on all LEDs
    press(1'b1, 1'b0, 3);
    cyc(20);
    chk("step_one", int'(stepcounter), 1);

    // saturation both ways
    for (int i = 0; i < 17; i++) press(1'b1, 1'b0, $urandom_range(1, 4));
    chk("sat_up", int'(stepcounter), 15);
    for (int i = 0; i < 17; i++) press(1'b0, 1'b1, $urandom_range(1, 4));
    chk("sat_down", int'(stepcounter), 0);

    // bar graph
    mode = 1'b1;
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 2);
    cyc(5);
    chk("bar_4", int'(leds), 10'h00F);
    for (int i = 0; i < 8; i++) press(1'b1, 1'b0, 2);
    cyc(5);
    chk("bar_12", int'(leds), 10'h3FF);
    mode = 1'b0;

    // simultaneous press at step 5
    for (int i = 0; i < 7; i++) press(1'b0, 1'b1, 2);
    press(1'b1, 1'b1, 3);
    chk("simultaneous", int'(stepcounter), 5);

    // button held through reset release, then a reset in the middle of a press
    up_n = 1'b0;
    do_reset(3);
    cyc(10);
    up_n = 1'b1;
    cyc(4);
    chk("held_thru_reset", int'(stepcounter), 0);
    @(negedge clock_50);
    up_n = 1'b0;
    do_reset(2);
    up_n = 1'b1;
    cyc(6);
    chk("rst_mid_press", int'(stepcounter), 0);

    // long period at step 8, then switch back to the short period with counter > 15
    for (int i = 0; i < 8; i++) press(1'b1, 1'b0, 2);
    test = 1'b0;
    cyc(1500);
    test = 1'b1;
    cyc(40);

    // random traffic
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: press(1'b1, 1'b0, $urandom_range(1, 4));
        3, 4, 5: press(1'b0, 1'b1, $urandom_range(1, 4));
        6:       press(1'b1, 1'b1, $urandom_range(1, 3));
        7:       begin mode = $urandom_range(0, 1); cyc($urandom_range(1, 8)); end
        8:       begin test = ($urandom_range(0, 3) != 0); cyc($urandom_range(1, 40)); end
        default: begin
          if ($urandom_range(0, 7) == 0) do_reset($urandom_range(1, 3));
          else cyc($urandom_range(1, 8));
        end
      endcase
    end

    cyc(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
